// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch_ctrl control/status bundle
// Purpose: groups the fetch controller's control inputs (hazard, ID resolver,
//          CP0) and its fetch outputs (PC, IM address, IF/ID controls).
// Ports (master drives controls and observes fetch outputs; slave is fetch_ctrl):
//   stall, branch, branch_addr, jump, jump_addr, exc_req, eret, epc -> slave
//   pc, pc_4, im_addr, ifid_en, ifid_flush, fetch_nop, fetch_adel, fetch_bd -> master
interface fetch_ctrl_if;
  logic        stall;
  logic        branch;
  logic [31:0] branch_addr;
  logic        jump;
  logic [31:0] jump_addr;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [11:0] im_addr;
  logic        ifid_en;
  logic        ifid_flush;
  logic        fetch_nop;
  logic        fetch_adel;
  logic        fetch_bd;

  modport master (
    output stall, branch, branch_addr, jump, jump_addr, exc_req, eret, epc,
    input  pc, pc_4, im_addr, ifid_en, ifid_flush, fetch_nop, fetch_adel, fetch_bd
  );

  modport slave (
    input  stall, branch, branch_addr, jump, jump_addr, exc_req, eret, epc,
    output pc, pc_4, im_addr, ifid_en, ifid_flush, fetch_nop, fetch_adel, fetch_bd
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - MIPS fetch-stage PC and IF/ID controller
// Purpose: owns the program counter; each cycle selects reset, exception
//          vector, eret return, stall hold, branch, jump or sequential PC,
//          and drives IM word address and IF/ID enable/flush/nop/AdEL/BD.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - fetch_ctrl_if.slave: control inputs and fetch outputs
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pc_inc;
  logic        redirect;

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = bus.exc_req | bus.eret;

  // exc_req beats eret beats stall; branch/jump are only honoured in RUN
  // because in REDIR the ID stage holds the flushed bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      state <= RUN;
    end else if (bus.exc_req) begin
      pc_q  <= EXC_PC;
      state <= REDIR;
    end else if (bus.eret) begin
      pc_q  <= bus.epc;
      state <= REDIR;
    end else begin
      state <= RUN;
      if (bus.stall)
        pc_q <= pc_q;
      else if (state == RUN && bus.branch)
        pc_q <= bus.branch_addr;
      else if (state == RUN && bus.jump)
        pc_q <= bus.jump_addr;
      else
        pc_q <= pc_inc;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_4       = pc_inc;
  assign bus.im_addr    = 12'((pc_q - IM_LO) >> 2);
  assign bus.ifid_flush = redirect;
  assign bus.ifid_en    = !bus.stall | redirect;
  assign bus.fetch_adel = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);
  assign bus.fetch_nop  = bus.fetch_adel;
  assign bus.fetch_bd   = (state == RUN) & (bus.branch | bus.jump);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed-vector bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, then let inputs/outputs settle away from the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.stall = 0; bus.branch = 0; bus.jump = 0; bus.exc_req = 0; bus.eret = 0;
    bus.branch_addr = 0; bus.jump_addr = 0; bus.epc = 0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    bus.jump = 1; bus.jump_addr = a;
    step();
    bus.jump = 0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    reset = 0;
    #1;
    check("rst_pc", bus.pc, 32'h3000);
    check("rst_pc4", bus.pc_4, 32'h3004);
    check("rst_im", 32'(bus.im_addr), 0);
    check("rst_en", 32'(bus.ifid_en), 1);
    check("rst_flush", 32'(bus.ifid_flush), 0);
    check("rst_nop", 32'(bus.fetch_nop), 0);
    check("rst_adel", 32'(bus.fetch_adel), 0);
    check("rst_bd", 32'(bus.fetch_bd), 0);

    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", bus.pc, 32'h3000 + 32'(4 * i));
      check("seq_im", 32'(bus.im_addr), 32'(i));
      check("seq_en", 32'(bus.ifid_en), 1);
    end

    jump_to(32'h3008);
    check("jmp_pc", bus.pc, 32'h3008);

    // taken branch at 0x3008
    bus.branch = 1; bus.branch_addr = 32'h3100;
    #1;
    check("br_bd", 32'(bus.fetch_bd), 1);
    step();
    bus.branch = 0;
    #1;
    check("br_pc", bus.pc, 32'h3100);
    check("br_bd_after", 32'(bus.fetch_bd), 0);

    // stall with branch held in ID
    jump_to(32'h3010);
    bus.stall = 1; bus.branch = 1; bus.branch_addr = 32'h3040;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stl_en", 32'(bus.ifid_en), 0);
      check("stl_bd", 32'(bus.fetch_bd), 1);
      step();
      check("stl_pc", bus.pc, 32'h3010);
    end
    bus.stall = 0;
    #1;
    check("rel_en", 32'(bus.ifid_en), 1);
    step();
    bus.branch = 0;
    #1;
    check("rel_pc", bus.pc, 32'h3040);

    // exception overrides stall
    jump_to(32'h3010);
    bus.stall = 1; bus.exc_req = 1;
    #1;
    check("exc_flush", 32'(bus.ifid_flush), 1);
    check("exc_en", 32'(bus.ifid_en), 1);
    step();
    bus.stall = 0; bus.exc_req = 0;
    bus.branch = 1; bus.branch_addr = 32'h3200;
    #1;
    check("exc_pc", bus.pc, 32'h4180);
    check("redir_bd", 32'(bus.fetch_bd), 0);
    step();
    bus.branch = 0;
    #1;
    check("redir_ign", bus.pc, 32'h4184);

    // eret, then eret+exc_req, then eret re-entering REDIR
    bus.eret = 1; bus.epc = 32'h3020;
    #1;
    check("eret_flush", 32'(bus.ifid_flush), 1);
    step();
    check("eret_pc", bus.pc, 32'h3020);
    bus.exc_req = 1;
    step();
    bus.exc_req = 0; bus.epc = 32'h3030;
    #1;
    check("both_pc", bus.pc, 32'h4180);
    step();
    bus.eret = 0;
    bus.branch = 1; bus.branch_addr = 32'h3200;
    #1;
    check("reent_pc", bus.pc, 32'h3030);
    step();
    bus.branch = 0;
    #1;
    check("reent_ign", bus.pc, 32'h3034);

    // fetch address boundaries
    jump_to(32'h3002);
    check("mis_pc", bus.pc, 32'h3002);
    check("mis_adel", 32'(bus.fetch_adel), 1);
    check("mis_nop", 32'(bus.fetch_nop), 1);
    jump_to(32'h7000);
    check("hi_adel", 32'(bus.fetch_adel), 1);
    jump_to(32'h6ffc);
    check("top_adel", 32'(bus.fetch_adel), 0);
    check("top_im", 32'(bus.im_addr), 32'hfff);
    step();
    check("top_next", bus.pc, 32'h7000);
    check("top_next_adel", 32'(bus.fetch_adel), 1);
    jump_to(32'h2ffc);
    check("lo_adel", 32'(bus.fetch_adel), 1);
    jump_to(32'h3000);
    check("lo_ok", 32'(bus.fetch_adel), 0);
    jump_to(32'hffff_fffc);
    check("wrap_pc4", bus.pc_4, 32'h0);
    step();
    check("wrap_pc", bus.pc, 32'h0);

    // reset wins mid-stall and mid-REDIR
    jump_to(32'h3050);
    bus.stall = 1; reset = 1;
    step();
    reset = 0;
    #1;
    check("rst_stall", bus.pc, 32'h3000);
    bus.stall = 0; bus.exc_req = 1;
    step();
    bus.exc_req = 0; reset = 1;
    step();
    reset = 0;
    #1;
    check("rst_redir", bus.pc, 32'h3000);
    bus.branch = 1; bus.branch_addr = 32'h3300;
    #1;
    check("rst_state", 32'(bus.fetch_bd), 1);
    step();
    bus.branch = 0;
    #1;
    check("rst_br", bus.pc, 32'h3300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
